eth_rx_link_ctrl: RTL

- Sequences bring-up of the 10GBASE-R receive path.
- Drives GT RX reset, releases and supervises the 66b block aligner, and runs a clause-49-style BER monitor on the sync-header stream.
- Produces a qualified o_link_up for the MAC.
- Sits between the GT wrapper / block aligner and the RX MAC in the i_clk (RX user clock) domain.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/eth_ber_monitor.sv | 85 ++++++++
 rtl/eth_rx_link_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// ============================================================================
// eth_pkg : shared types and sync-header helpers for the 10GBASE-R RX path
// Rev 1.0
// ============================================================================
`default_nettype none

package eth_pkg;

    typedef enum logic [1:0] {
        GT_RESET = 2'd0,
        WAIT_GT  = 2'd1,
        ALIGN    = 2'd2,
        LOCKED   = 2'd3
    } rx_link_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    function automatic logic is_valid_sync(input logic [1:0] header);
        return (header == SYNC_DATA) || (header == SYNC_CTRL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_ber_monitor.sv
// ============================================================================
// eth_ber_monitor : windowed invalid-sync-header counter with hi_ber flag
// Rev 1.0
// ============================================================================
`default_nettype none

module eth_ber_monitor
    import eth_pkg::*;
#(
    parameter int BER_WINDOW_CYCLES  = 19531,
    parameter int BER_THRESHOLD      = 16,
    parameter int HI_BER_MAX_WINDOWS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_header,
    input  logic       i_header_valid,
    output logic       o_hi_ber,
    output logic       o_bad_max
);

    localparam int c_win_w = $clog2(BER_WINDOW_CYCLES + 1);
    localparam int c_inv_w = $clog2(BER_THRESHOLD + 1);
    localparam int c_bad_w = $clog2(HI_BER_MAX_WINDOWS + 1);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(BER_WINDOW_CYCLES - 1);
    localparam logic [c_inv_w-1:0] c_thr      = c_inv_w'(BER_THRESHOLD);
    localparam logic [c_bad_w-1:0] c_bad_max  = c_bad_w'(HI_BER_MAX_WINDOWS);

    logic [c_win_w-1:0] r_win_cnt;
    logic [c_inv_w-1:0] r_inv_cnt;
    logic [c_bad_w-1:0] r_bad_cnt;
    logic               r_hi_ber;
    logic [c_inv_w-1:0] w_inv_next;
    logic               w_invalid;
    logic               w_win_end;

    // w_inv_next includes the current header so a window-end header still counts
    always_comb begin
        w_invalid  = i_header_valid && !is_valid_sync(i_header);
        w_win_end  = (r_win_cnt == c_win_last);
        w_inv_next = r_inv_cnt;
        if (w_invalid && (r_inv_cnt < c_thr)) begin
            w_inv_next = r_inv_cnt + c_inv_w'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win_cnt <= '0;
            r_inv_cnt <= '0;
            r_bad_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (!i_en) begin
            r_win_cnt <= '0;
            r_inv_cnt <= '0;
            r_bad_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (w_win_end) begin
            r_win_cnt <= '0;
            r_inv_cnt <= '0;
            if (w_inv_next < c_thr) begin
                r_hi_ber  <= 1'b0;
                r_bad_cnt <= '0;
            end else begin
                r_hi_ber <= 1'b1;
                if (r_bad_cnt < c_bad_max) begin
                    r_bad_cnt <= r_bad_cnt + c_bad_w'(1);
                end
            end
        end else begin
            r_win_cnt <= r_win_cnt + c_win_w'(1);
            r_inv_cnt <= w_inv_next;
            if (w_inv_next == c_thr) begin
                r_hi_ber <= 1'b1;
            end
        end
    end

    assign o_hi_ber  = r_hi_ber;
    assign o_bad_max = (r_bad_cnt == c_bad_max);

endmodule

`default_nettype wire

// File: rtl/eth_rx_link_ctrl.sv
// ============================================================================
// eth_rx_link_ctrl : 10GBASE-R RX bring-up sequencer, BER supervision, link_up
// Optional stats ports with ETH_RX_LINK_CTRL_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module eth_rx_link_ctrl
    import eth_pkg::*;
#(
    parameter int GT_RESET_CYCLES     = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 1_000_000,
    parameter int BER_WINDOW_CYCLES   = 19531,
    parameter int BER_THRESHOLD       = 16,
    parameter int HI_BER_MAX_WINDOWS  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_gt_rx_reset_done,
    input  logic        i_block_lock,
    input  logic [1:0]  i_header,
    input  logic        i_header_valid,
    output logic        o_gt_rx_reset,
    output logic        o_align_rst_n,
    output logic        o_hi_ber,
    output logic        o_link_up,
`ifdef ETH_RX_LINK_CTRL_STATS_EN
    output logic [15:0] o_lock_loss_count,
    output logic [15:0] o_hi_ber_count,
`endif
    output logic [7:0]  o_retry_count
);

    localparam int c_gt_w = $clog2(GT_RESET_CYCLES + 1);
    localparam int c_to_w = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam logic [c_gt_w-1:0] c_gt_last = c_gt_w'(GT_RESET_CYCLES - 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(LOCK_TIMEOUT_CYCLES - 1);

    rx_link_state_t     r_state;
    logic [c_gt_w-1:0]  r_gt_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_gt_rx_reset;
    logic               r_align_rst_n;
    logic               r_link_up;
    logic [7:0]         r_retry_cnt;
    logic               w_hi_ber;
    logic               w_bad_max;
    logic               w_ber_en;

    // Monitor runs only on cycles that stay in LOCKED, so any exit or entry clears it
    assign w_ber_en = (r_state == LOCKED) && i_gt_rx_reset_done && i_block_lock && !w_bad_max;

    eth_ber_monitor #(
        .BER_WINDOW_CYCLES  (BER_WINDOW_CYCLES),
        .BER_THRESHOLD      (BER_THRESHOLD),
        .HI_BER_MAX_WINDOWS (HI_BER_MAX_WINDOWS)
    ) u_ber (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (w_ber_en),
        .i_header       (i_header),
        .i_header_valid (i_header_valid),
        .o_hi_ber       (w_hi_ber),
        .o_bad_max      (w_bad_max)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= GT_RESET;
            r_gt_cnt      <= '0;
            r_to_cnt      <= '0;
            r_gt_rx_reset <= 1'b1;
            r_align_rst_n <= 1'b0;
            r_link_up     <= 1'b0;
            r_retry_cnt   <= '0;
        end else begin
            r_link_up <= (r_state == LOCKED) && !w_hi_ber;
            case (r_state)
                GT_RESET: begin
                    if (r_gt_cnt == c_gt_last) begin
                        r_state       <= WAIT_GT;
                        r_gt_cnt      <= '0;
                        r_gt_rx_reset <= 1'b0;
                    end else begin
                        r_gt_cnt <= r_gt_cnt + c_gt_w'(1);
                    end
                end
                WAIT_GT: begin
                    if (i_gt_rx_reset_done) begin
                        r_state       <= ALIGN;
                        r_to_cnt      <= '0;
                        r_align_rst_n <= 1'b1;
                    end
                end
                ALIGN: begin
                    if (!i_gt_rx_reset_done) begin
                        r_state       <= GT_RESET;
                        r_gt_rx_reset <= 1'b1;
                        r_align_rst_n <= 1'b0;
                    end else if (i_block_lock) begin
                        r_state <= LOCKED;
                    end else if (r_to_cnt == c_to_last) begin
                        r_state       <= GT_RESET;
                        r_gt_rx_reset <= 1'b1;
                        r_align_rst_n <= 1'b0;
                        if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_to_w'(1);
                    end
                end
                LOCKED: begin
                    if (!i_gt_rx_reset_done) begin
                        r_state       <= GT_RESET;
                        r_gt_rx_reset <= 1'b1;
                        r_align_rst_n <= 1'b0;
                    end else if (!i_block_lock) begin
                        r_state  <= ALIGN;
                        r_to_cnt <= '0;
                    end else if (w_bad_max) begin
                        r_state       <= GT_RESET;
                        r_gt_rx_reset <= 1'b1;
                        r_align_rst_n <= 1'b0;
                        if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
                    end
                end
                default: r_state <= GT_RESET;
            endcase
        end
    end

    assign o_gt_rx_reset = r_gt_rx_reset;
    assign o_align_rst_n = r_align_rst_n;
    assign o_hi_ber      = w_hi_ber;
    assign o_link_up     = r_link_up;
    assign o_retry_count = r_retry_cnt;

`ifdef ETH_RX_LINK_CTRL_STATS_EN
    logic [15:0] r_lock_loss_cnt;
    logic [15:0] r_hi_ber_cnt;
    logic        r_hi_ber_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_loss_cnt <= '0;
            r_hi_ber_cnt    <= '0;
            r_hi_ber_d      <= 1'b0;
        end else begin
            r_hi_ber_d <= w_hi_ber;
            if (w_hi_ber && !r_hi_ber_d && (r_hi_ber_cnt != 16'hFFFF)) begin
                r_hi_ber_cnt <= r_hi_ber_cnt + 16'd1;
            end
            if ((r_state == LOCKED) && i_gt_rx_reset_done && !i_block_lock
                    && (r_lock_loss_cnt != 16'hFFFF)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
            end
        end
    end

    assign o_lock_loss_count = r_lock_loss_cnt;
    assign o_hi_ber_count    = r_hi_ber_cnt;
`endif

endmodule

`default_nettype wire
